// File: rtl/mac_accumulator_pkg.sv
// Shared definitions for the multiply-accumulate stage.
package mac_accumulator_pkg;

    localparam int ACC_W_DEF = 24;
    localparam int COUNT_MAX = 255;

    // Group state at the input side: IDLE means the next accepted element opens a group.
    typedef enum logic {
        IDLE = 1'b0,
        OPEN = 1'b1
    } grp_state_t;

endpackage

// File: rtl/barrel_multiplier.sv
// Combinational 8x8 multiplier, unsigned or two's-complement.
// Signed operands are reduced to magnitudes (8 bits is enough, -128 -> 0x80),
// multiplied by shift-and-add, and the sign reapplied, so -128*-128 = +16384.
module barrel_multiplier (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic        sgn,
    output logic [15:0] p
);

    logic        neg_a;
    logic        neg_b;
    logic [7:0]  mag_a;
    logic [7:0]  mag_b;
    logic [15:0] mag_p;

    // Magnitude multiply via shifted partial products, then restore sign.
    always_comb begin
        neg_a = sgn & a[7];
        neg_b = sgn & b[7];
        mag_a = neg_a ? (~a + 8'd1) : a;
        mag_b = neg_b ? (~b + 8'd1) : b;
        mag_p = '0;
        for (int i = 0; i < 8; i++) begin
            if (mag_b[i]) mag_p = mag_p + ({8'd0, mag_a} << i);
        end
        p = (neg_a ^ neg_b) ? (~mag_p + 16'd1) : mag_p;
    end

endmodule

// File: rtl/mac_accumulator.sv
// Streaming multiply-accumulate: operand pairs in, one group sum out per 'last'.
// S1 registers the accepted pair; on the following edge its product is folded
// into the accumulator, and a last element loads the result register instead.
module mac_accumulator
    import mac_accumulator_pkg::*;
#(
    parameter int ACC_W    = ACC_W_DEF,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic             in_signed,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_signed,
    output logic             out_ovf,
    output logic [7:0]       out_count
);

    localparam logic [ACC_W-1:0] S_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] S_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [ACC_W-1:0] U_MAX = '1;

    logic             s1_valid, s1_mode, s1_last;
    logic [7:0]       s1_a, s1_b;
    grp_state_t       state;
    logic             grp_mode;
    logic [ACC_W-1:0] acc;
    logic             sticky;
    logic [7:0]       count;

    logic             accept, res_free, s1_fire, mode_sel;
    logic [15:0]      prod;
    logic [ACC_W-1:0] prod_ext, acc_next;
    logic [ACC_W:0]   sum_w;
    logic             ovf_now;
    logic [7:0]       count_inc;

    assign in_ready = !(out_valid && !out_ready);
    assign accept   = in_valid && in_ready;
    assign res_free = !out_valid || out_ready;
    // A last element waits in S1 only if the result register is still owed downstream
    // (possible with back-to-back single-element groups); other elements always retire.
    assign s1_fire  = s1_valid && (!s1_last || res_free);
    assign mode_sel = (state == IDLE) ? in_signed : grp_mode;

    barrel_multiplier u_mul (
        .a   (s1_a),
        .b   (s1_b),
        .sgn (s1_mode),
        .p   (prod)
    );

    // Extend product, add with one guard bit, detect overflow and clamp or wrap.
    always_comb begin
        prod_ext       = {ACC_W{s1_mode & prod[15]}};
        prod_ext[15:0] = prod;
        sum_w   = {s1_mode & acc[ACC_W-1], acc} + {s1_mode & prod_ext[ACC_W-1], prod_ext};
        ovf_now = s1_mode ? (sum_w[ACC_W] ^ sum_w[ACC_W-1]) : sum_w[ACC_W];
        acc_next = sum_w[ACC_W-1:0];
        if (SATURATE && ovf_now) begin
            if (!s1_mode)          acc_next = U_MAX;
            else if (sum_w[ACC_W]) acc_next = S_MIN;
            else                   acc_next = S_MAX;
        end
        count_inc = (count == 8'(COUNT_MAX)) ? count : count + 8'd1;
    end

    // S1 operand register and input-side group FSM; the group closes when last is accepted
    // so a new group's first element can arrive on the very next cycle with its own mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_mode  <= 1'b0;
            s1_last  <= 1'b0;
            state    <= IDLE;
            grp_mode <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_a     <= in_a;
                s1_b     <= in_b;
                s1_mode  <= mode_sel;
                s1_last  <= in_last;
                grp_mode <= mode_sel;
                state    <= in_last ? IDLE : OPEN;
            end else if (s1_fire) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Running accumulator, sticky overflow and element count; cleared as a group closes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            sticky <= 1'b0;
            count  <= '0;
        end else if (s1_fire) begin
            if (s1_last) begin
                acc    <= '0;
                sticky <= 1'b0;
                count  <= '0;
            end else begin
                acc    <= acc_next;
                sticky <= sticky | ovf_now;
                count  <= count_inc;
            end
        end
    end

    // Result register: loads on a retiring last, otherwise drains on out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_acc    <= '0;
            out_signed <= 1'b0;
            out_ovf    <= 1'b0;
            out_count  <= '0;
        end else if (s1_fire && s1_last) begin
            out_valid  <= 1'b1;
            out_acc    <= acc_next;
            out_signed <= s1_mode;
            out_ovf    <= sticky | ovf_now;
            out_count  <= count_inc;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// Scoreboard bench: three instances (24-bit saturating, 16-bit saturating,
// 16-bit wrapping) share one stimulus stream; each has its own expected queue.
module tb_mac_accumulator;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       in_valid = 1'b0, in_signed = 1'b0, in_last = 1'b0, out_ready = 1'b1;
    logic [7:0] in_a = '0, in_b = '0;

    logic        rdy0, rdy1, rdy2, v0, v1, v2, sg0, sg1, sg2, of0, of1, of2;
    logic [23:0] acc0;
    logic [15:0] acc1, acc2;
    logic [7:0]  cnt0, cnt1, cnt2;

    mac_accumulator #(.ACC_W(24), .SATURATE(1'b1)) u24 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0), .in_a(in_a),
        .in_b(in_b), .in_signed(in_signed), .in_last(in_last), .out_valid(v0),
        .out_ready(out_ready), .out_acc(acc0), .out_signed(sg0), .out_ovf(of0),
        .out_count(cnt0));

    mac_accumulator #(.ACC_W(16), .SATURATE(1'b1)) u16s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1), .in_a(in_a),
        .in_b(in_b), .in_signed(in_signed), .in_last(in_last), .out_valid(v1),
        .out_ready(out_ready), .out_acc(acc1), .out_signed(sg1), .out_ovf(of1),
        .out_count(cnt1));

    mac_accumulator #(.ACC_W(16), .SATURATE(1'b0)) u16w (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2), .in_a(in_a),
        .in_b(in_b), .in_signed(in_signed), .in_last(in_last), .out_valid(v2),
        .out_ready(out_ready), .out_acc(acc2), .out_signed(sg2), .out_ovf(of2),
        .out_count(cnt2));

    typedef struct {
        logic [31:0] acc;
        logic        ovf;
        logic [7:0]  cnt;
        logic        sgn;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] a24, input logic o24, input logic [31:0] a16s,
                        input logic o16s, input logic [31:0] a16w, input logic o16w,
                        input logic [7:0] c, input logic s);
        q0.push_back('{acc: a24,  ovf: o24,  cnt: c, sgn: s});
        q1.push_back('{acc: a16s, ovf: o16s, cnt: c, sgn: s});
        q2.push_back('{acc: a16w, ovf: o16w, cnt: c, sgn: s});
    endtask

    // Compare a presented result against the queue head; pop only on a real transfer.
    task automatic mon(input int idx, input logic v, input logic [31:0] acc, input logic ovf,
                       input logic [7:0] cnt, input logic sgn);
        exp_t e;
        int   n;
        if (!v) return;
        n = (idx == 0) ? q0.size() : (idx == 1) ? q1.size() : q2.size();
        if (n == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result inst%0d actual=%0h expected=none", idx, acc);
            return;
        end
        e = (idx == 0) ? q0[0] : (idx == 1) ? q1[0] : q2[0];
        chk($sformatf("inst%0d out_acc", idx), acc, e.acc);
        chk($sformatf("inst%0d out_ovf", idx), 32'(ovf), 32'(e.ovf));
        chk($sformatf("inst%0d out_count", idx), 32'(cnt), 32'(e.cnt));
        chk($sformatf("inst%0d out_signed", idx), 32'(sgn), 32'(e.sgn));
        if (out_ready) begin
            if (idx == 0) void'(q0.pop_front());
            else if (idx == 1) void'(q1.pop_front());
            else void'(q2.pop_front());
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, v0, 32'(acc0), of0, cnt0, sg0);
            mon(1, v1, 32'(acc1), of1, cnt1, sg1);
            mon(2, v2, 32'(acc2), of2, cnt2, sg2);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one pair and hold it until accepted (bounded wait).
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic s, input logic l);
        int n = 0;
        in_valid = 1'b1; in_a = a; in_b = b; in_signed = s; in_last = l;
        forever begin
            @(negedge clk);
            if (rdy0) break;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL in_ready_timeout actual=0 expected=1");
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, " out_valid"}, 32'({v0, v1, v2}), 32'd0);
        chk({tag, " out_acc24"}, 32'(acc0), 32'd0);
        chk({tag, " out_acc16"}, 32'({acc1, acc2}), 32'd0);
        chk({tag, " out_ovf"}, 32'({of0, of1, of2}), 32'd0);
        chk({tag, " out_signed"}, 32'({sg0, sg1, sg2}), 32'd0);
        chk({tag, " out_count"}, 32'({cnt0, cnt1, cnt2}), 32'd0);
        chk({tag, " in_ready"}, 32'({rdy0, rdy1, rdy2}), 32'h7);
    endtask

    time t_start;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk_reset_outs("reset");
        rst_n = 1'b1;
        cyc(2);

        // 1: unsigned group 12+30+49 = 91, check latency and single-cycle valid
        push(91, 0, 91, 0, 91, 0, 3, 0);
        send(8'd3, 8'd4, 1'b0, 1'b0);
        send(8'd5, 8'd6, 1'b0, 1'b0);
        send(8'd7, 8'd7, 1'b0, 1'b1);
        idle();
        @(negedge clk); chk("lat edge+0 out_valid", 32'(v0), 32'd0);
        @(negedge clk); chk("lat edge+1 out_valid", 32'(v0), 32'd1);
        @(negedge clk); chk("lat edge+2 out_valid", 32'(v0), 32'd0);
        cyc(1);

        // 2: signed -56+64 = 8; then mode locked signed despite in_signed=0: 0 + (-1*-1) = 1
        push(8, 0, 8, 0, 8, 0, 2, 1);
        send(8'hF8, 8'h07, 1'b1, 1'b0);
        send(8'hF8, 8'hF8, 1'b1, 1'b1);
        push(1, 0, 1, 0, 1, 0, 2, 1);
        send(8'h00, 8'h05, 1'b1, 1'b0);
        send(8'hFF, 8'hFF, 1'b0, 1'b1);
        idle();
        cyc(4);

        // 3: overflow: 2*65025 = 130050 (0x1FC02); 2*16384 = 32768
        push(32'h01FC02, 0, 32'hFFFF, 1, 32'hFC02, 1, 2, 0);
        send(8'hFF, 8'hFF, 1'b0, 1'b0);
        send(8'hFF, 8'hFF, 1'b0, 1'b1);
        push(32'h008000, 0, 32'h7FFF, 1, 32'h8000, 1, 2, 1);
        send(8'h80, 8'h80, 1'b1, 1'b0);
        send(8'h80, 8'h80, 1'b1, 1'b1);
        idle();
        cyc(4);

        // 4: backpressure, groups 2+12 = 14 and 30+56 = 86
        out_ready = 1'b0;
        push(14, 0, 14, 0, 14, 0, 2, 0);
        push(86, 0, 86, 0, 86, 0, 2, 0);
        fork
            begin
                send(8'd1, 8'd2, 1'b0, 1'b0);
                send(8'd3, 8'd4, 1'b0, 1'b1);
                send(8'd5, 8'd6, 1'b0, 1'b0);
                send(8'd7, 8'd8, 1'b0, 1'b1);
                idle();
            end
            begin
                cyc(4);
                @(negedge clk);
                chk("bp held out_valid", 32'(v0), 32'd1);
                chk("bp in_ready low", 32'({rdy0, rdy1, rdy2}), 32'd0);
                @(negedge clk);
                chk("bp in_ready still low", 32'({rdy0, rdy1, rdy2}), 32'd0);
                cyc(1);
                out_ready = 1'b1;
                cyc(1);
                out_ready = 1'b0;
                cyc(4);
                out_ready = 1'b1;
            end
        join
        cyc(4);

        // 5: single-element groups back-to-back, k*k, one per cycle
        out_ready = 1'b1;
        t_start = $time;
        for (int k = 0; k < 16; k++) begin
            push(32'(k * k), 0, 32'(k * k), 0, 32'(k * k), 0, 1, 0);
            send(8'(k), 8'(k), 1'b0, 1'b1);
        end
        chk("stream no bubble time", 32'($time - t_start), 32'd160);
        idle();
        cyc(4);

        // 6: reset mid-group, then a clean group 2*3 = 6
        send(8'd1, 8'd1, 1'b0, 1'b0);
        send(8'd2, 8'd2, 1'b0, 1'b0);
        idle();
        #2 rst_n = 1'b0;
        #1 chk_reset_outs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1);
        push(6, 0, 6, 0, 6, 0, 1, 0);
        send(8'd2, 8'd3, 1'b0, 1'b1);
        idle();
        cyc(5);

        chk("results outstanding", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop in case something above never returns.
    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule
